// File: rtl/op_mode_controller.sv
// Mode sequencer: qualifies a stable op code, launches the selected unit on confirm,
// tracks it to done or aborts it on a switch change. Optional run timeout: OP_CTRL_TIMEOUT_EN.
module op_mode_controller #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] op,
    input  logic       confirm,
    input  logic [4:0] unit_done,
    output logic [4:0] start,
    output logic [4:0] abort,
    output logic [2:0] active_op,
    output logic       busy,
    output logic [1:0] state_code,
    output logic       err
);

    localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state_reg;
    logic [2:0]       op_q_reg;
    logic [CNT_W-1:0] stable_cnt_reg;
    logic [4:0]       op_q_mask;
    logic [4:0]       active_mask;
    logic             op_stable;
    logic             off_stable;
    logic             done_hit;
    logic             switch_moved;
    logic             timeout_hit;

    // Stability tracker runs in every state; ERROR exit also relies on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q_reg       <= '0;
            stable_cnt_reg <= '0;
        end else begin
            op_q_reg <= op;
            if (op != op_q_reg)
                stable_cnt_reg <= '0;
            else if (stable_cnt_reg != CNT_MAX)
                stable_cnt_reg <= stable_cnt_reg + 1'b1;
        end
    end

    assign op_stable  = (stable_cnt_reg == CNT_MAX) && (op_q_reg >= 3'd1) && (op_q_reg <= 3'd5);
    assign off_stable = (stable_cnt_reg == CNT_MAX) && (op_q_reg == 3'd0);

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_masks
            assign op_q_mask[gi]   = (op_q_reg == 3'(gi + 1));
            assign active_mask[gi] = (active_op == 3'(gi + 1));
        end
    endgenerate

    assign done_hit     = |(unit_done & active_mask);
    assign switch_moved = (op_q_reg != active_op);

`ifdef OP_CTRL_TIMEOUT_EN
    logic [31:0] run_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            run_cnt_reg <= '0;
        else if (state_reg == S_LAUNCH)
            run_cnt_reg <= '0;
        else if (state_reg == S_RUN)
            run_cnt_reg <= run_cnt_reg + 32'd1;
    end

    // Fires in the TIMEOUT_CYCLES-th RUN cycle (counter starts at 0 in the first one).
    assign timeout_hit = (run_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
`else
    // Never true; the parameter stays referenced so both builds share one interface.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            start      <= '0;
            abort      <= '0;
            active_op  <= '0;
            busy       <= 1'b0;
            state_code <= 2'd0;
            err        <= 1'b0;
        end else begin
            start <= '0;
            abort <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (confirm) begin
                        if (op_stable) begin
                            state_reg  <= S_LAUNCH;
                            active_op  <= op_q_reg;
                            start      <= op_q_mask;
                            busy       <= 1'b1;
                            state_code <= 2'd1;
                        end else begin
                            state_reg  <= S_ERROR;
                            err        <= 1'b1;
                            state_code <= 2'd3;
                        end
                    end
                end
                S_LAUNCH: begin
                    state_reg <= S_RUN;
                end
                S_RUN: begin
                    // Done takes priority over both a switch change and a timeout.
                    if (done_hit) begin
                        state_reg  <= S_DONE;
                        busy       <= 1'b0;
                        state_code <= 2'd2;
                    end else if (switch_moved || timeout_hit) begin
                        state_reg  <= S_ERROR;
                        abort      <= active_mask;
                        err        <= 1'b1;
                        busy       <= 1'b0;
                        state_code <= 2'd3;
                    end
                end
                S_DONE: begin
                    if (confirm || switch_moved) begin
                        state_reg  <= S_IDLE;
                        active_op  <= '0;
                        state_code <= 2'd0;
                    end
                end
                S_ERROR: begin
                    if (off_stable) begin
                        state_reg  <= S_IDLE;
                        active_op  <= '0;
                        err        <= 1'b0;
                        state_code <= 2'd0;
                    end
                end
                default: begin
                    state_reg  <= S_IDLE;
                    active_op  <= '0;
                    busy       <= 1'b0;
                    err        <= 1'b0;
                    state_code <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_op_mode_controller.sv
// Directed table-driven bench for op_mode_controller with hand-computed expectations.
module tb_op_mode_controller;

    logic       clk;
    logic       rst_n;
    logic [2:0] op;
    logic       confirm;
    logic [4:0] unit_done;
    logic [4:0] start;
    logic [4:0] abort;
    logic [2:0] active_op;
    logic       busy;
    logic [1:0] state_code;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    op_mode_controller #(
        .STABLE_CYCLES (16),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .confirm   (confirm),
        .unit_done (unit_done),
        .start     (start),
        .abort     (abort),
        .active_op (active_op),
        .busy      (busy),
        .state_code(state_code),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         rep;
        logic [2:0] op;
        logic       confirm;
        logic [4:0] done;
        logic [4:0] e_start;
        logic [4:0] e_abort;
        logic [2:0] e_act;
        logic       e_busy;
        logic [1:0] e_sc;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int rep, input logic [2:0] o, input logic c, input logic [4:0] d,
                       input logic [4:0] es, input logic [4:0] ea, input logic [2:0] eact,
                       input logic eb, input logic [1:0] esc, input logic ee);
        vec_t v;
        v.rep = rep; v.op = o; v.confirm = c; v.done = d;
        v.e_start = es; v.e_abort = ea; v.e_act = eact;
        v.e_busy = eb; v.e_sc = esc; v.e_err = ee;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic [4:0] es, input logic [4:0] ea,
                                 input logic [2:0] eact, input logic eb, input logic [1:0] esc,
                                 input logic ee);
        check("start",      idx, 32'(start),      32'(es));
        check("abort",      idx, 32'(abort),      32'(ea));
        check("active_op",  idx, 32'(active_op),  32'(eact));
        check("busy",       idx, 32'(busy),       32'(eb));
        check("state_code", idx, 32'(state_code), 32'(esc));
        check("err",        idx, 32'(err),        32'(ee));
    endtask

    initial begin
        // rep, op, confirm, done | start, abort, active_op, busy, state_code, err
        // Launch op 3, run, done, confirm back to IDLE
        add(20, 3'd3, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        add(1,  3'd3, 1'b1, 5'b00000, 5'b00100, 5'b00000, 3'd3, 1'b1, 2'd1, 1'b0);
        add(1,  3'd3, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd3, 1'b1, 2'd1, 1'b0);
        add(5,  3'd3, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd3, 1'b1, 2'd1, 1'b0);
        add(1,  3'd3, 1'b0, 5'b00100, 5'b00000, 5'b00000, 3'd3, 1'b0, 2'd2, 1'b0);
        add(1,  3'd3, 1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        // Op 4 run to DONE, DONE holds, confirm returns to IDLE
        add(20, 3'd4, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        add(1,  3'd4, 1'b1, 5'b00000, 5'b01000, 5'b00000, 3'd4, 1'b1, 2'd1, 1'b0);
        add(1,  3'd4, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd4, 1'b1, 2'd1, 1'b0);
        add(1,  3'd4, 1'b0, 5'b01000, 5'b00000, 5'b00000, 3'd4, 1'b0, 2'd2, 1'b0);
        add(3,  3'd4, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd4, 1'b0, 2'd2, 1'b0);
        add(1,  3'd4, 1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        // Op 1 held only 10 cycles: confirm errors; op 0 for 17 edges still ERROR, 18th exits
        add(10, 3'd1, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        add(1,  3'd1, 1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd3, 1'b1);
        add(17, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd3, 1'b1);
        add(1,  3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        // Confirm with a stable op 0 is an error; already-stable 0 exits next cycle
        add(1,  3'd0, 1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd3, 1'b1);
        add(1,  3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        // Op 2 running, switch moves to 5: abort one cycle later (op_q lag), held one cycle only
        add(20, 3'd2, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        add(1,  3'd2, 1'b1, 5'b00000, 5'b00010, 5'b00000, 3'd2, 1'b1, 2'd1, 1'b0);
        add(1,  3'd2, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b1, 2'd1, 1'b0);
        add(1,  3'd5, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b1, 2'd1, 1'b0);
        add(1,  3'd5, 1'b0, 5'b00000, 5'b00000, 5'b00010, 3'd2, 1'b0, 2'd3, 1'b1);
        add(1,  3'd5, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b0, 2'd3, 1'b1);
        add(17, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b0, 2'd3, 1'b1);
        add(1,  3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        // Done and switch change seen together: done wins; then switch change leaves DONE
        add(20, 3'd2, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        add(1,  3'd2, 1'b1, 5'b00000, 5'b00010, 5'b00000, 3'd2, 1'b1, 2'd1, 1'b0);
        add(1,  3'd2, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b1, 2'd1, 1'b0);
        add(1,  3'd5, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b1, 2'd1, 1'b0);
        add(1,  3'd5, 1'b0, 5'b00010, 5'b00000, 5'b00000, 3'd2, 1'b0, 2'd2, 1'b0);
        add(1,  3'd5, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        // Op 6 is invalid even when stable
        add(20, 3'd6, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        add(1,  3'd6, 1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd3, 1'b1);
        add(17, 3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd3, 1'b1);
        add(1,  3'd0, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        // Op 1 running: foreign done bits and confirm are ignored
        add(20, 3'd1, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 2'd0, 1'b0);
        add(1,  3'd1, 1'b1, 5'b00000, 5'b00001, 5'b00000, 3'd1, 1'b1, 2'd1, 1'b0);
        add(1,  3'd1, 1'b0, 5'b00000, 5'b00000, 5'b00000, 3'd1, 1'b1, 2'd1, 1'b0);
        add(1,  3'd1, 1'b0, 5'b00010, 5'b00000, 5'b00000, 3'd1, 1'b1, 2'd1, 1'b0);
        add(1,  3'd1, 1'b1, 5'b00000, 5'b00000, 5'b00000, 3'd1, 1'b1, 2'd1, 1'b0);
        add(1,  3'd1, 1'b0, 5'b11110, 5'b00000, 5'b00000, 3'd1, 1'b1, 2'd1, 1'b0);

        // Reset with op 3 held
        rst_n     = 1'b0;
        op        = 3'd3;
        confirm   = 1'b0;
        unit_done = 5'b00000;
        repeat (3) @(posedge clk);
        #1;
        check_outputs(-1, 5'b0, 5'b0, 3'd0, 1'b0, 2'd0, 1'b0);
        $display("reset: start=%b abort=%b active_op=%0d busy=%b state_code=%0d err=%b",
                 start, abort, active_op, busy, state_code, err);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].rep; r++) begin
                op        = vecs[i].op;
                confirm   = vecs[i].confirm;
                unit_done = vecs[i].done;
                @(posedge clk);
                #1;
            end
            check_outputs(i, vecs[i].e_start, vecs[i].e_abort, vecs[i].e_act,
                          vecs[i].e_busy, vecs[i].e_sc, vecs[i].e_err);
            $display("vec %0d: op=%0d confirm=%b done=%b x%0d -> start=%b abort=%b active_op=%0d busy=%b state_code=%0d err=%b",
                     i, vecs[i].op, vecs[i].confirm, vecs[i].done, vecs[i].rep,
                     start, abort, active_op, busy, state_code, err);
        end

        // Still in RUN for op 1: reset mid-cycle must clear outputs before the next edge
        op        = 3'd1;
        confirm   = 1'b0;
        unit_done = 5'b00000;
        rst_n     = 1'b0;
        #1;
        check_outputs(100, 5'b0, 5'b0, 3'd0, 1'b0, 2'd0, 1'b0);
        $display("async reset mid-run: active_op=%0d busy=%b state_code=%0d err=%b",
                 active_op, busy, state_code, err);

        // Held in reset across an edge with confirm high: nothing launches
        confirm = 1'b1;
        @(posedge clk);
        #1;
        check_outputs(101, 5'b0, 5'b0, 3'd0, 1'b0, 2'd0, 1'b0);
        $display("held reset with confirm: start=%b state_code=%0d", start, state_code);
        confirm = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard wall-clock bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
